status_capture: RTL and testbench

//  Receive-side monitor for the 9-bit input_status word driven by the status

---
 rtl/status_capture_if.sv | 24 ++
 rtl/status_capture.sv | 127 ++++++++++++
 tb/tb_status_capture.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/status_capture_if.sv
// Read port of the status capture block: level request, one-cycle
// acknowledge, and the flag/overflow snapshot taken at the read.
interface status_capture_if #(
    parameter int WIDTH = 9
);
    logic             rd_req;
    logic             rd_ack;
    logic [WIDTH-1:0] rd_data;
    logic             rd_ovf;

    modport master (
        output rd_req,
        input  rd_ack,
        input  rd_data,
        input  rd_ovf
    );

    modport slave (
        input  rd_req,
        output rd_ack,
        output rd_data,
        output rd_ovf
    );
endinterface

// File: rtl/status_capture.sv
// Status word monitor: per-bit sync and debounce, sticky change flags,
// clear-on-read snapshot port and a masked, registered interrupt.
module status_capture #(
    parameter int WIDTH       = 9,
    parameter int SYNC_STAGES = 2,
    parameter int STABLE_CNT  = 4,
    parameter int CNT_W       = 3
) (
    input  logic             sysclk,
    input  logic             reset,
    input  logic [WIDTH-1:0] status_in,
    input  logic [WIDTH-1:0] irq_mask,
    status_capture_if.slave  rd,
    output logic [WIDTH-1:0] status_q,
    output logic [WIDTH-1:0] change_flags,
    output logic             overflow,
    output logic             irq
);

    localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(STABLE_CNT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACK  = 2'd1,
        WAIT = 2'd2
    } state_t;

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [CNT_W-1:0] cnt    [WIDTH];
    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] ev;
    logic             ovf_ev;
    logic             capture;
    state_t           state;
    state_t           state_nxt;

    assign s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < SYNC_STAGES; k++)
                sync_q[k] <= '0;
        end else begin
            sync_q[0] <= status_in;
            for (int k = 1; k < SYNC_STAGES; k++)
                sync_q[k] <= sync_q[k-1];
        end
    end

    // A bit is accepted only after STABLE_CNT consecutive mismatching cycles
    always_comb begin
        ev = '0;
        for (int i = 0; i < WIDTH; i++)
            ev[i] = (s[i] != status_q[i]) && (cnt[i] == CNT_TOP);
    end

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            status_q <= '0;
            for (int i = 0; i < WIDTH; i++)
                cnt[i] <= '0;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (s[i] == status_q[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_TOP) begin
                    status_q[i] <= s[i];
                    cnt[i]      <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        rd.rd_ack = 1'b0;
        unique case (state)
            IDLE: begin
                if (rd.rd_req) begin
                    capture   = 1'b1;
                    state_nxt = ACK;
                end
            end
            ACK: begin
                rd.rd_ack = 1'b1;
                state_nxt = WAIT;
            end
            WAIT: begin
                if (!rd.rd_req)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // New events take priority over the clear done by a capture
    assign ovf_ev = |(ev & change_flags);

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            change_flags <= '0;
            overflow     <= 1'b0;
            irq          <= 1'b0;
            rd.rd_data   <= '0;
            rd.rd_ovf    <= 1'b0;
        end else begin
            change_flags <= ev | (capture ? '0 : change_flags);
            overflow     <= ovf_ev | (overflow & ~capture);
            irq          <= |(change_flags & ~irq_mask);
            if (capture) begin
                rd.rd_data <= change_flags;
                rd.rd_ovf  <= overflow;
            end
        end
    end

endmodule

// File: tb/tb_status_capture.sv
// Directed bench for status_capture: debounce latency, glitch rejection,
// clear-on-read, set-wins race, irq masking and reset during a read.
module tb_status_capture;

    logic       sysclk = 1'b0;
    logic       reset;
    logic [8:0] status_in;
    logic [8:0] irq_mask;
    logic [8:0] status_q;
    logic [8:0] change_flags;
    logic       overflow;
    logic       irq;

    int n_checks = 0;
    int n_fail   = 0;

    status_capture_if #(.WIDTH(9)) rd_if ();

    status_capture dut (
        .sysclk       (sysclk),
        .reset        (reset),
        .status_in    (status_in),
        .irq_mask     (irq_mask),
        .rd           (rd_if),
        .status_q     (status_q),
        .change_flags (change_flags),
        .overflow     (overflow),
        .irq          (irq)
    );

    always #5 sysclk = ~sysclk;

    task automatic tick();
        @(posedge sysclk);
        #1;
    endtask

    task automatic check(input string tag, input logic [8:0] obs,
                         input logic [8:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_read(input string tag, input logic [8:0] exp);
        rd_if.rd_req = 1'b1;
        tick();
        check({tag, "_ack"}, 9'(rd_if.rd_ack), 9'd1);
        check({tag, "_data"}, rd_if.rd_data, exp);
        rd_if.rd_req = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        reset        = 1'b0;
        status_in    = '0;
        irq_mask     = '0;
        rd_if.rd_req = 1'b0;
        tick();
        tick();
        check("rst_status_q", status_q, 9'h000);
        check("rst_flags", change_flags, 9'h000);
        check("rst_misc", {4'd0, overflow, irq, rd_if.rd_ack,
                           rd_if.rd_ovf, 1'b0}, 9'h000);
        check("rst_rd_data", rd_if.rd_data, 9'h000);
        reset = 1'b1;
        tick();

        // status_in rises ahead of edge 0; accepted on edge 5
        status_in = 9'h001;
        tick();
        repeat (4) tick();
        check("lat_e4_status_q", status_q, 9'h000);
        tick();
        check("lat_e5_status_q", status_q, 9'h001);
        check("lat_e5_flags", change_flags, 9'h001);
        check("lat_e5_irq", 9'(irq), 9'd0);
        tick();
        check("lat_e6_irq", 9'(irq), 9'd1);

        // three-cycle pulse on bit 3 must be rejected
        status_in = 9'h009;
        repeat (3) tick();
        status_in = 9'h001;
        repeat (10) tick();
        check("glitch_status_q", status_q, 9'h001);
        check("glitch_flags", change_flags, 9'h001);
        check("glitch_irq", 9'(irq), 9'd1);

        do_read("clr0", 9'h001);
        check("clr0_flags", change_flags, 9'h000);

        // bit 2 toggles twice before a read
        status_in = 9'h005;
        repeat (10) tick();
        status_in = 9'h001;
        repeat (10) tick();
        check("ovf_flags", change_flags, 9'h004);
        check("ovf_set", 9'(overflow), 9'd1);
        rd_if.rd_req = 1'b1;
        tick();
        check("rd3_ack", 9'(rd_if.rd_ack), 9'd1);
        check("rd3_data", rd_if.rd_data, 9'h004);
        check("rd3_ovf", 9'(rd_if.rd_ovf), 9'd1);
        check("rd3_flags_clr", change_flags, 9'h000);
        check("rd3_ovf_clr", 9'(overflow), 9'd0);
        tick();
        check("rd3_ack_drop", 9'(rd_if.rd_ack), 9'd0);
        check("rd3_irq_clr", 9'(irq), 9'd0);
        repeat (3) tick();
        check("rd3_no_reack", 9'(rd_if.rd_ack), 9'd0);
        rd_if.rd_req = 1'b0;
        tick();
        tick();

        // bit 5 event lands on the capture edge
        status_in = 9'h021;
        tick();
        repeat (4) tick();
        rd_if.rd_req = 1'b1;
        tick();
        check("race_status_q", status_q, 9'h021);
        check("race_ack", 9'(rd_if.rd_ack), 9'd1);
        check("race_data", rd_if.rd_data, 9'h000);
        check("race_flags", change_flags, 9'h020);
        check("race_no_ovf", 9'(overflow), 9'd0);
        rd_if.rd_req = 1'b0;
        tick();
        check("race_irq", 9'(irq), 9'd1);
        tick();
        do_read("race_rd2", 9'h020);
        check("race_rd2_flags", change_flags, 9'h000);

        // masked bit 7 sets its flag but not irq
        irq_mask  = 9'h1FF;
        status_in = 9'h0A1;
        repeat (8) tick();
        check("mask_flags", change_flags, 9'h080);
        check("mask_irq", 9'(irq), 9'd0);
        irq_mask = 9'h000;
        tick();
        check("unmask_irq", 9'(irq), 9'd1);
        do_read("mask_rd", 9'h080);

        // reset while the ack is high
        rd_if.rd_req = 1'b1;
        tick();
        check("rst_ack_pre", 9'(rd_if.rd_ack), 9'd1);
        #2;
        reset = 1'b0;
        #1;
        check("rst_ack_async", 9'(rd_if.rd_ack), 9'd0);
        check("rst_mid_flags", change_flags, 9'h000);
        check("rst_mid_status", status_q, 9'h000);
        reset = 1'b1;
        tick();
        check("rst_new_ack", 9'(rd_if.rd_ack), 9'd1);
        check("rst_new_data", rd_if.rd_data, 9'h000);
        rd_if.rd_req = 1'b0;
        tick();
        check("rst_new_drop", 9'(rd_if.rd_ack), 9'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
